// File: rtl/trigger_quiescent_pkg.sv
// Shared types and constants for the quiescent actor trigger.
// States, trigger modes, the EXECUTED return code and width helpers.
package trigger_quiescent_pkg;

    typedef enum logic [2:0] {
        IDLE_STATE,
        LAUNCH,
        CHECK,
        SLEEP,
        SYNC_LAUNCH,
        SYNC_CHECK,
        SYNC_WAIT,
        SYNC_EXEC
    } state_t;

    typedef enum logic {
        ACTOR_TRIGGER,
        OUTPUT_TRIGGER
    } mode_t;

    // Actor return code meaning "did useful work this invocation".
    localparam int unsigned EXECUTED = 1;

    // Quiet-round counter holds values up to 14 (QUIET_ROUNDS <= 15).
    typedef logic [3:0] quiet_t;

    // Width able to hold timeout-1; never less than one bit.
    function automatic int unsigned tmr_width(input int unsigned timeout);
        if (timeout > 2) begin
            return $clog2(timeout);
        end
        return 1;
    endfunction

endpackage

// File: rtl/trigger_sat_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset.
// Clear wins over increment; the count sticks at all-ones.
module trigger_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         ap_clk,
    input  logic         ap_rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;

    // Count register: clear, saturating increment
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/trigger_quiescent.sv
// Actor trigger: relaunches one HLS actor, sleeps when it stalls, joins the
// network-wide sync rounds and raises ap_done after QUIET_ROUNDS consecutive
// all-wait rounds. Optional firing statistics under macro TRIGGER_STATS_EN.
module trigger_quiescent
    import trigger_quiescent_pkg::*;
#(
    parameter mode_t       MODE          = ACTOR_TRIGGER,
    parameter int unsigned RET_W         = 32,
    parameter int unsigned QUIET_ROUNDS  = 2,
    parameter int unsigned SLEEP_TIMEOUT = 0,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_ready,
    output logic             ap_idle,
    input  logic             external_enqueue,
    input  logic             all_sync,
    input  logic             all_sync_wait,
    input  logic             all_sleep,
    output logic             sleep,
    output logic             sync_exec,
    output logic             sync_wait,
    input  logic [RET_W-1:0] actor_return,
    input  logic             actor_done,
    input  logic             actor_ready,
    input  logic             actor_idle,
    output logic             actor_start,
    output logic [CNT_W-1:0] fire_count,
    output logic [CNT_W-1:0] timeout_count
);

    localparam int unsigned TMR_W    = tmr_width(SLEEP_TIMEOUT);
    localparam int unsigned TMO_LAST = (SLEEP_TIMEOUT == 0) ? 0 : SLEEP_TIMEOUT - 1;
    localparam quiet_t      Q_LAST   = quiet_t'(QUIET_ROUNDS - 1);

    state_t             state_q, state_d;
    state_t             sl_state, ts_state;
    quiet_t             quiet_q;
    logic [TMR_W-1:0]   sleep_tmr;
    logic               exec;
    logic               timeout_hit;
    logic               done;
    logic               quiet_clr, quiet_inc;
    logic               cnt_clr, fire_inc, tmo_inc;
    logic               tmr_clr, tmr_inc;

    logic unused_inputs;
    assign unused_inputs = ^{actor_ready, actor_idle};

    assign exec        = (actor_return == RET_W'(EXECUTED));
    assign timeout_hit = (SLEEP_TIMEOUT != 0) && (sleep_tmr == TMR_W'(TMO_LAST));

    // Mode-dependent targets after a productive (SL) or stalled (TS) invocation
    always_comb begin
        sl_state = LAUNCH;
        ts_state = SLEEP;
        if (MODE == OUTPUT_TRIGGER) begin
            sl_state = SLEEP;
            ts_state = IDLE_STATE;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_d   = state_q;
        done      = 1'b0;
        quiet_clr = 1'b0;
        quiet_inc = 1'b0;
        cnt_clr   = 1'b0;
        fire_inc  = 1'b0;
        tmo_inc   = 1'b0;
        case (state_q)
            IDLE_STATE: begin
                if (ap_start) begin
                    state_d   = sl_state;
                    quiet_clr = 1'b1;
                    cnt_clr   = 1'b1;
                end
            end
            LAUNCH, CHECK: begin
                if (actor_done) begin
                    fire_inc = exec;
                    if (exec || external_enqueue) begin
                        state_d = sl_state;
                    end else begin
                        state_d = ts_state;
                    end
                end else begin
                    state_d = CHECK;
                end
            end
            SLEEP: begin
                // Network-wide sleep beats a local timeout in the same cycle
                if (all_sleep) begin
                    if (MODE == ACTOR_TRIGGER) begin
                        state_d = SYNC_LAUNCH;
                    end else begin
                        state_d = LAUNCH;
                    end
                end else if (timeout_hit) begin
                    state_d = LAUNCH;
                    tmo_inc = 1'b1;
                end
            end
            SYNC_LAUNCH, SYNC_CHECK: begin
                if (actor_done) begin
                    fire_inc = exec;
                    if (exec) begin
                        state_d = SYNC_EXEC;
                    end else begin
                        state_d = SYNC_WAIT;
                    end
                end else begin
                    state_d = SYNC_CHECK;
                end
            end
            SYNC_EXEC: begin
                if (all_sync) begin
                    state_d   = LAUNCH;
                    quiet_clr = 1'b1;
                end
            end
            SYNC_WAIT: begin
                if (all_sync && !all_sync_wait) begin
                    state_d   = LAUNCH;
                    quiet_clr = 1'b1;
                end else if (all_sync && all_sync_wait) begin
                    if (quiet_q == Q_LAST) begin
                        state_d = IDLE_STATE;
                        done    = 1'b1;
                    end else begin
                        state_d   = SYNC_LAUNCH;
                        quiet_inc = 1'b1;
                    end
                end
            end
            default: state_d = IDLE_STATE;
        endcase
    end

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Consecutive all-wait round counter
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            quiet_q <= '0;
        end else if (quiet_clr) begin
            quiet_q <= '0;
        end else if (quiet_inc) begin
            quiet_q <= quiet_q + 1'b1;
        end
    end

    // Sleep timer restarts on each SLEEP entry and runs while SLEEP persists
    always_comb begin
        tmr_clr = (state_d == SLEEP) && (state_q != SLEEP);
        tmr_inc = (state_d == SLEEP) && (state_q == SLEEP);
    end

    trigger_sat_counter #(
        .W (TMR_W)
    ) u_sleep_tmr (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .clr      (tmr_clr),
        .inc      (tmr_inc),
        .q        (sleep_tmr)
    );

`ifdef TRIGGER_STATS_EN
    trigger_sat_counter #(
        .W (CNT_W)
    ) u_fire_cnt (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .clr      (cnt_clr),
        .inc      (fire_inc),
        .q        (fire_count)
    );

    trigger_sat_counter #(
        .W (CNT_W)
    ) u_timeout_cnt (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .clr      (cnt_clr),
        .inc      (tmo_inc),
        .q        (timeout_count)
    );
`else
    assign fire_count    = '0;
    assign timeout_count = '0;

    logic unused_stats;
    assign unused_stats = ^{cnt_clr, fire_inc, tmo_inc};
`endif

    // Moore status outputs decoded from state; ap_done is the Mealy exit pulse
    always_comb begin
        ap_idle     = (state_q == IDLE_STATE);
        sleep       = (state_q == SLEEP);
        sync_exec   = (state_q == SYNC_EXEC);
        sync_wait   = (state_q == SYNC_WAIT);
        actor_start = (state_q == LAUNCH) || (state_q == SYNC_LAUNCH);
        ap_done     = done;
        ap_ready    = done;
    end

endmodule

// File: tb/tb_trigger_quiescent.sv
// Scoreboard bench for trigger_quiescent (ACTOR mode, QUIET_ROUNDS=2,
// SLEEP_TIMEOUT=8). Stimulus pushes expected ap_done events; a negedge
// monitor pops and compares them when the DUT pulses ap_done.
module tb_trigger_quiescent;
    import trigger_quiescent_pkg::*;

    localparam int unsigned RET_W = 32;
    localparam int unsigned CNT_W = 32;
`ifdef TRIGGER_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic             ap_clk = 1'b0;
    logic             ap_rst_n;
    logic             ap_start;
    logic             ap_done, ap_ready, ap_idle;
    logic             external_enqueue;
    logic             all_sync, all_sync_wait, all_sleep;
    logic             sleep, sync_exec, sync_wait;
    logic [RET_W-1:0] actor_return;
    logic             actor_done, actor_ready, actor_idle;
    logic             actor_start;
    logic [CNT_W-1:0] fire_count, timeout_count;

    typedef struct {
        int cyc;
        int fire;
        int tmo;
    } done_exp_t;

    done_exp_t exp_q[$];
    done_exp_t mon_e;
    int        checks   = 0;
    int        failures = 0;
    int        cyc      = 0;

    trigger_quiescent #(
        .MODE          (ACTOR_TRIGGER),
        .RET_W         (RET_W),
        .QUIET_ROUNDS  (2),
        .SLEEP_TIMEOUT (8),
        .CNT_W         (CNT_W)
    ) dut (
        .ap_clk           (ap_clk),
        .ap_rst_n         (ap_rst_n),
        .ap_start         (ap_start),
        .ap_done          (ap_done),
        .ap_ready         (ap_ready),
        .ap_idle          (ap_idle),
        .external_enqueue (external_enqueue),
        .all_sync         (all_sync),
        .all_sync_wait    (all_sync_wait),
        .all_sleep        (all_sleep),
        .sleep            (sleep),
        .sync_exec        (sync_exec),
        .sync_wait        (sync_wait),
        .actor_return     (actor_return),
        .actor_done       (actor_done),
        .actor_ready      (actor_ready),
        .actor_idle       (actor_idle),
        .actor_start      (actor_start),
        .fire_count       (fire_count),
        .timeout_count    (timeout_count)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic start_run(output int s);
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        s = cyc;
    endtask

    task automatic push_done(input int c, input int f, input int t);
        done_exp_t e;
        e.cyc  = c;
        e.fire = f;
        e.tmo  = t;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int n;
        n = 0;
        tick();
        while (!ap_idle && n < max_cyc) begin
            tick();
            n++;
        end
        check(name, ap_idle, 1);
    endtask

    // Monitor: every ap_done pulse must match the next expected completion
    always @(negedge ap_clk) begin
        if (ap_rst_n === 1'b1 && ap_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: ap_done=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_cycle", cyc, mon_e.cyc);
                check("done_fire_count", fire_count, mon_e.fire);
                check("done_timeout_count", timeout_count, mon_e.tmo);
                check("done_ap_ready", ap_ready, 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        ap_rst_n         = 1'b0;
        ap_start         = 1'b0;
        external_enqueue = 1'b0;
        all_sync         = 1'b0;
        all_sync_wait    = 1'b0;
        all_sleep        = 1'b0;
        actor_return     = '0;
        actor_done       = 1'b0;
        actor_ready      = 1'b0;
        actor_idle       = 1'b0;

        // Reset values: only ap_idle high
        #12;
        check("reset_flags", {actor_start, ap_idle, sleep, sync_exec, sync_wait, ap_done, ap_ready},
              7'b0100000);
        check("reset_counts", {fire_count, timeout_count}, 64'd0);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        tick();
        tick();

        // A: stalled actor, network fully quiet -> done in second all-wait round
        all_sleep     = 1'b1;
        all_sync      = 1'b1;
        all_sync_wait = 1'b1;
        actor_done    = 1'b1;
        actor_return  = '0;
        start_run(s);
        push_done(s + 5, 0, 0);
        wait_idle("a_idle", 30);

        // B: second round sees a busy peer -> relaunch, quiet count restarts
        start_run(s);
        push_done(s + 11, 0, 0);
        wait_until(s + 5);
        check("b_sync_wait", sync_wait, 1);
        all_sync_wait = 1'b0;
        tick();
        all_sync_wait = 1'b1;
        wait_idle("b_idle", 30);

        // C: sleep timeout relaunches 8 cycles after SLEEP entry
        all_sleep = 1'b0;
        start_run(s);
        push_done(s + 14, 0, STATS);
        wait_until(s + 8);
        check("c_start_low_in_sleep", {actor_start, sleep}, 2'b01);
        tick();
        check("c_start_after_timeout", actor_start, 1);
        check("c_timeout_count", timeout_count, STATS);
        all_sleep = 1'b1;
        wait_idle("c_idle", 30);

        // D: all_sleep in the timeout cycle wins -> SYNC_LAUNCH, no timeout
        all_sleep = 1'b0;
        start_run(s);
        push_done(s + 12, 0, 0);
        wait_until(s + 8);
        all_sleep = 1'b1;
        tick();
        check("d_actor_start", actor_start, 1);
        check("d_timeout_count", timeout_count, 0);
        wait_idle("d_idle", 30);

        // E: five EXECUTED returns, then stall and quiesce
        actor_return = RET_W'(EXECUTED);
        start_run(s);
        push_done(s + 10, 5 * STATS, 0);
        wait_until(s + 5);
        actor_return = '0;
        wait_idle("e_idle", 30);

        // F: next start clears counters; reset in CHECK returns to idle at once
        actor_done = 1'b0;
        start_run(s);
        check("f_fire_cleared", fire_count, 0);
        check("f_launch_start", actor_start, 1);
        tick();
        check("f_check_state", {actor_start, ap_idle}, 2'b00);
        #1;
        ap_rst_n = 1'b0;
        #1;
        check("f_reset_check_flags",
              {actor_start, ap_idle, sleep, sync_exec, sync_wait, ap_done, ap_ready}, 7'b0100000);
        check("f_reset_check_counts", {fire_count, timeout_count}, 64'd0);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        tick();

        // G: reset while in LAUNCH drops actor_start without a clock edge
        start_run(s);
        check("g_launch_start", actor_start, 1);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("g_reset_launch_flags", {actor_start, ap_idle}, 2'b01);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        tick();
        tick();
        check("g_idle_after_reset", ap_idle, 1);

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
